led_dimmer_ctrl: RTL and testbench

- Multi-channel LED brightness controller: two push-buttons step a per-channel brightness level up or down.
- Hold-to-auto-repeat and saturation at both ends.
- Each level drives a glitch-free PWM output.
- Sits between the synchronised button inputs and the LED pins; generalises the single-signal up/down controller to N channels, configurable width and press/hold timing.

---
 rtl/led_dimmer_pkg.sv | 25 ++
 rtl/led_dimmer_ctrl_pwm_gen.sv | 37 +++
 rtl/led_dimmer_ctrl.sv | 146 ++++++++++++++
 tb/tb_led_dimmer_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_dimmer_pkg.sv
// Shared types and default constants for the multi-channel LED dimmer.
package led_dimmer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RPT,
    LOCK
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_t;

  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_LEVEL_W       = 7;
  localparam int DEF_HOLD_CYCLES   = 125;
  localparam int DEF_REPEAT_CYCLES = 25;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_dimmer_ctrl_pwm_gen.sv
// Shared PWM counter, per-channel shadow levels and registered comparators.
module led_pwm_gen
  import led_dimmer_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int LEVEL_W  = DEF_LEVEL_W
) (
  input  logic                clk,
  input  logic                res,
  input  logic [LEVEL_W-1:0]  level [CHANNELS],
  output logic [CHANNELS-1:0] pwm
);

  // Period is LMAX cycles, so a full-scale level keeps the output high throughout.
  localparam logic [LEVEL_W-1:0] PC_LAST = LEVEL_W'((2 ** LEVEL_W) - 2);

  logic [LEVEL_W-1:0] pc;
  logic [LEVEL_W-1:0] al [CHANNELS];
  logic               wrap;

  assign wrap = (pc == PC_LAST);

  always_ff @(posedge clk) begin
    if (!res) begin
      pc  <= '0;
      pwm <= '0;
      for (int i = 0; i < CHANNELS; i++) al[i] <= '0;
    end else begin
      pc <= wrap ? '0 : pc + LEVEL_W'(1);
      for (int i = 0; i < CHANNELS; i++) begin
        pwm[i] <= (pc < al[i]);
        if (wrap) al[i] <= level[i];
      end
    end
  end

endmodule

// File: rtl/led_dimmer_ctrl.sv
// Two-button brightness editor with hold-to-repeat over N channels,
// each channel driving a glitch-free PWM output.
module led_dimmer_ctrl
  import led_dimmer_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int SEL_W         = sel_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                btn_up,
  input  logic                btn_dn,
  input  logic [SEL_W-1:0]    chan_sel,
  output logic [CHANNELS-1:0] pwm,
  output logic [LEVEL_W-1:0]  level_o,
  output logic                at_limit
);

  // state | meaning
  // IDLE  | waiting for a single-button press on a valid channel
  // ARM   | button held, counting down to first auto-repeat
  // RPT   | auto-repeating every REPEAT_CYCLES while held
  // LOCK  | both buttons seen together, no steps until both released

  localparam logic [LEVEL_W-1:0] LMAX = '1;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LOAD  = CNT_W'(REPEAT_CYCLES - 1);

  state_t             state, state_nx;
  dir_t               dir_q, dir_nx, step_dir;
  logic [SEL_W-1:0]   ch_q, ch_nx, step_ch;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic               swap_q, swap_nx;
  logic               up_q, dn_q, up_ok_q, dn_ok_q;
  logic               up_go, dn_go, held, other, sel_ok, step_en;
  logic [LEVEL_W-1:0] wl [CHANNELS];

  function automatic logic [LEVEL_W-1:0] sat_step(input logic [LEVEL_W-1:0] v, input dir_t d);
    if (d == DIR_UP) return (v == LMAX) ? v : v + LEVEL_W'(1);
    return (v == '0) ? v : v - LEVEL_W'(1);
  endfunction

  assign sel_ok = ({1'b0, chan_sel} < (SEL_W + 1)'(CHANNELS));
  assign held   = (dir_q == DIR_UP) ? btn_up : btn_dn;
  assign other  = (dir_q == DIR_UP) ? btn_dn : btn_up;

  // up_ok/dn_ok mask a button still held through reset; swap_q carries a
  // release-and-other-press edge into IDLE so it is taken on the next edge.
  assign up_go = (btn_up & ~up_q & up_ok_q) | (swap_q & btn_up & (dir_q == DIR_DN));
  assign dn_go = (btn_dn & ~dn_q & dn_ok_q) | (swap_q & btn_dn & (dir_q == DIR_UP));

  always_comb begin
    state_nx = state;
    dir_nx   = dir_q;
    ch_nx    = ch_q;
    cnt_nx   = cnt_q;
    swap_nx  = 1'b0;
    step_en  = 1'b0;
    step_dir = dir_q;
    step_ch  = ch_q;
    case (state)
      IDLE: begin
        if (sel_ok && (up_go || dn_go)) begin
          ch_nx = chan_sel;
          if (btn_up && btn_dn) begin
            state_nx = LOCK;
          end else begin
            step_en  = 1'b1;
            step_ch  = chan_sel;
            step_dir = up_go ? DIR_UP : DIR_DN;
            dir_nx   = step_dir;
            cnt_nx   = HOLD_LOAD;
            state_nx = ARM;
          end
        end
      end
      ARM, RPT: begin
        if (!held) begin
          state_nx = IDLE;
          swap_nx  = other;
        end else if (other) begin
          state_nx = LOCK;
        end else if (cnt_q == '0) begin
          step_en  = 1'b1;
          cnt_nx   = REP_LOAD;
          state_nx = RPT;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      LOCK: begin
        if (!btn_up && !btn_dn) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state   <= IDLE;
      dir_q   <= DIR_UP;
      ch_q    <= '0;
      cnt_q   <= '0;
      swap_q  <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      up_ok_q <= ~btn_up;
      dn_ok_q <= ~btn_dn;
      for (int i = 0; i < CHANNELS; i++) wl[i] <= '0;
    end else begin
      state   <= state_nx;
      dir_q   <= dir_nx;
      ch_q    <= ch_nx;
      cnt_q   <= cnt_nx;
      swap_q  <= swap_nx;
      up_q    <= btn_up;
      dn_q    <= btn_dn;
      up_ok_q <= up_ok_q | ~btn_up;
      dn_ok_q <= dn_ok_q | ~btn_dn;
      if (step_en) wl[step_ch] <= sat_step(wl[step_ch], step_dir);
    end
  end

  always_comb begin
    level_o = wl[ch_q];
    if (state == IDLE) level_o = sel_ok ? wl[chan_sel] : '0;
  end

  assign at_limit = (level_o == '0) || (level_o == LMAX);

  led_pwm_gen #(
    .CHANNELS(CHANNELS),
    .LEVEL_W (LEVEL_W)
  ) u_pwm (
    .clk  (clk),
    .res  (res),
    .level(wl),
    .pwm  (pwm)
  );

endmodule

// File: tb/tb_led_dimmer_ctrl.sv
// Directed scoreboard bench for led_dimmer_ctrl (4 channels, 4-bit levels, hold 8, repeat 3).
module tb_led_dimmer_ctrl;

  logic       clk = 1'b0;
  logic       res, btn_up, btn_dn;
  logic [1:0] chan_sel;
  logic [3:0] pwm;
  logic [3:0] level_o;
  logic       at_limit;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   mdl[4];
  int   hi;
  logic [3:0] others;

  always #5 clk = ~clk;

  led_dimmer_ctrl #(
    .CHANNELS     (4),
    .LEVEL_W      (4),
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk     (clk),
    .res     (res),
    .btn_up  (btn_up),
    .btn_dn  (btn_dn),
    .chan_sel(chan_sel),
    .pwm     (pwm),
    .level_o (level_o),
    .at_limit(at_limit)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%0d", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
  endtask

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 15) ? 15 : v);
  endfunction

  // Steps produced by holding a button for n sampled edges (hold 8, repeat 3).
  function automatic int hold_steps(input int n);
    return 1 + ((n > 8) ? 1 + (n - 9) / 3 : 0);
  endfunction

  task automatic pulse_up();
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    tick();
  endtask

  task automatic hold_btn(input bit up, input int n);
    if (up) btn_up = 1'b1; else btn_dn = 1'b1;
    tick(n);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick();
  endtask

  task automatic pwm_window(input int ch, output int h, output logic [3:0] oth);
    h   = 0;
    oth = '0;
    repeat (15) begin
      @(negedge clk);
      h   += int'(pwm[ch]);
      oth |= pwm & ~(4'b0001 << ch);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    res = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; chan_sel = 2'd0;

    // reset state
    push("rst_level", 0); push("rst_at_limit", 1); push("rst_pwm", 0);
    tick(3);
    check(32'(level_o)); check(32'(at_limit)); check(32'(pwm));
    res = 1'b1;
    tick();

    // three single-cycle pulses on channel 2
    chan_sel = 2'd2;
    mdl[2] = sat(mdl[2] + 3);
    push("pulse_level", 32'(mdl[2])); push("pulse_at_limit", 0);
    repeat (3) pulse_up();
    check(32'(level_o)); check(32'(at_limit));
    push("pwm2_duty", 3); push("pwm_others_low", 0);
    tick(20);
    pwm_window(2, hi, others);
    check(32'(hi)); check(32'(others));

    // hold 20 cycles on channel 1
    chan_sel = 2'd1;
    mdl[1] = sat(mdl[1] + hold_steps(20));
    push("hold20_level", 32'(mdl[1]));
    hold_btn(1'b1, 20);
    check(32'(level_o));

    // saturate up then down on channel 0
    chan_sel = 2'd0;
    mdl[0] = sat(mdl[0] + hold_steps(100));
    push("sat_hi_level", 32'(mdl[0])); push("sat_hi_at_limit", 1); push("pwm0_full", 15);
    hold_btn(1'b1, 100);
    check(32'(level_o)); check(32'(at_limit));
    tick(20);
    pwm_window(0, hi, others);
    check(32'(hi));
    mdl[0] = sat(mdl[0] - hold_steps(100));
    push("sat_lo_level", 32'(mdl[0])); push("sat_lo_at_limit", 1); push("pwm0_off", 0);
    hold_btn(1'b0, 100);
    check(32'(level_o)); check(32'(at_limit));
    tick(20);
    pwm_window(0, hi, others);
    check(32'(hi));

    // simultaneous press locks out stepping
    chan_sel = 2'd1;
    push("lock_level", 32'(mdl[1]));
    btn_up = 1'b1; btn_dn = 1'b1;
    tick(20);
    btn_dn = 1'b0;
    tick(10);
    check(32'(level_o));
    btn_up = 1'b0;
    tick();
    mdl[1] = sat(mdl[1] + 1);
    push("after_lock_level", 32'(mdl[1]));
    pulse_up();
    check(32'(level_o));

    // chan_sel change mid-hold is ignored
    chan_sel = 2'd1;
    push("sel_mid_hold", 32'(sat(mdl[1] + 1)));
    btn_up = 1'b1;
    tick(5);
    chan_sel = 2'd3;
    #1;
    check(32'(level_o));
    mdl[1] = sat(mdl[1] + hold_steps(20));
    push("ch3_untouched", 32'(mdl[3])); push("ch1_stepped", 32'(mdl[1]));
    tick(15);
    btn_up = 1'b0;
    tick();
    check(32'(level_o));
    chan_sel = 2'd1;
    #1;
    check(32'(level_o));
    chan_sel = 2'd3;
    mdl[3] = sat(mdl[3] + 1);
    push("ch3_next_press", 32'(mdl[3]));
    pulse_up();
    check(32'(level_o));

    // reset during auto-repeat with button held
    chan_sel = 2'd0;
    push("rpt_before_rst", 32'(sat(mdl[0] + hold_steps(12))));
    btn_up = 1'b1;
    tick(12);
    check(32'(level_o));
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    push("midrst_level", 0); push("midrst_at_limit", 1); push("midrst_pwm", 0);
    res = 1'b0;
    tick(2);
    check(32'(level_o)); check(32'(at_limit)); check(32'(pwm));
    res = 1'b1;
    push("held_no_step", 0); push("ch2_cleared", 32'(mdl[2]));
    tick(15);
    check(32'(level_o));
    chan_sel = 2'd2;
    #1;
    check(32'(level_o));
    chan_sel = 2'd0;
    btn_up = 1'b0;
    tick();
    mdl[0] = sat(mdl[0] + 1);
    push("repress_level", 32'(mdl[0])); push("pwm0_duty1", 1); push("pwm_rest_low", 0);
    pulse_up();
    check(32'(level_o));
    tick(20);
    pwm_window(0, hi, others);
    check(32'(hi)); check(32'(others));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
